// File: rtl/axi_io_pmp_rd_gate.sv
// AXI IO-PMP read-channel gate: holds one read at a time, asks the PMP
// checker about its address and either forwards it downstream or answers
// locally with a full-length DECERR burst.
module axi_io_pmp_rd_gate #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int ID_WIDTH     = 8,
  parameter int ARUSER_WIDTH = 1,
  parameter int RUSER_WIDTH  = 1,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  // slave AR
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arlock,
  input  logic [3:0]              s_axi_arcache,
  input  logic [2:0]              s_axi_arprot,
  input  logic [3:0]              s_axi_arqos,
  input  logic [3:0]              s_axi_arregion,
  input  logic [ARUSER_WIDTH-1:0] s_axi_aruser,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  // slave R
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic [RUSER_WIDTH-1:0]  s_axi_ruser,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  // master AR
  output logic [ID_WIDTH-1:0]     m_axi_arid,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic                    m_axi_arlock,
  output logic [3:0]              m_axi_arcache,
  output logic [2:0]              m_axi_arprot,
  output logic [3:0]              m_axi_arqos,
  output logic [3:0]              m_axi_arregion,
  output logic [ARUSER_WIDTH-1:0] m_axi_aruser,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  // master R
  input  logic [ID_WIDTH-1:0]     m_axi_rid,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic [RUSER_WIDTH-1:0]  m_axi_ruser,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  // PMP checker and status
  output logic [ADDR_WIDTH-1:0]   pmp_addr_o,
  input  logic                    pmp_allow_i,
  input  logic                    bypass_i,
  output logic [CNT_WIDTH-1:0]    denied_cnt_o,
  output logic [ADDR_WIDTH-1:0]   last_denied_addr_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_FWD_AR,
    ST_FWD_R,
    ST_ERR_R
  } state_t;

  state_t                  r_state;
  logic [ID_WIDTH-1:0]     r_arid;
  logic [ADDR_WIDTH-1:0]   r_araddr;
  logic [7:0]              r_arlen;
  logic [2:0]              r_arsize;
  logic [1:0]              r_arburst;
  logic                    r_arlock;
  logic [3:0]              r_arcache;
  logic [2:0]              r_arprot;
  logic [3:0]              r_arqos;
  logic [3:0]              r_arregion;
  logic [ARUSER_WIDTH-1:0] r_aruser;
  logic [7:0]              r_beat_cnt;
  logic [CNT_WIDTH-1:0]    r_denied_cnt;
  logic [ADDR_WIDTH-1:0]   r_last_denied_addr;

  // Sequencer: latch a request, take the checker verdict once, then either forward or answer with DECERR beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state            <= ST_IDLE;
      r_arid             <= '0;
      r_araddr           <= '0;
      r_arlen            <= '0;
      r_arsize           <= '0;
      r_arburst          <= '0;
      r_arlock           <= 1'b0;
      r_arcache          <= '0;
      r_arprot           <= '0;
      r_arqos            <= '0;
      r_arregion         <= '0;
      r_aruser           <= '0;
      r_beat_cnt         <= '0;
      r_denied_cnt       <= '0;
      r_last_denied_addr <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (s_axi_arvalid) begin
            r_arid     <= s_axi_arid;
            r_araddr   <= s_axi_araddr;
            r_arlen    <= s_axi_arlen;
            r_arsize   <= s_axi_arsize;
            r_arburst  <= s_axi_arburst;
            r_arlock   <= s_axi_arlock;
            r_arcache  <= s_axi_arcache;
            r_arprot   <= s_axi_arprot;
            r_arqos    <= s_axi_arqos;
            r_arregion <= s_axi_arregion;
            r_aruser   <= s_axi_aruser;
            r_state    <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (pmp_allow_i || bypass_i) begin
            r_state <= ST_FWD_AR;
          end else begin
            r_state            <= ST_ERR_R;
            r_beat_cnt         <= r_arlen;
            r_last_denied_addr <= r_araddr;
            if (r_denied_cnt != {CNT_WIDTH{1'b1}}) begin
              r_denied_cnt <= r_denied_cnt + CNT_WIDTH'(1);
            end
          end
        end
        ST_FWD_AR: begin
          if (m_axi_arready) begin
            r_state <= ST_FWD_R;
          end
        end
        ST_FWD_R: begin
          if (m_axi_rvalid && s_axi_rready && m_axi_rlast) begin
            r_state <= ST_IDLE;
          end
        end
        ST_ERR_R: begin
          if (s_axi_rready) begin
            if (r_beat_cnt == 8'd0) begin
              r_state <= ST_IDLE;
            end else begin
              r_beat_cnt <= r_beat_cnt - 8'd1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Handshake and R-channel steering decoded from the state; all valids/readies are forced low while reset is held.
  always_comb begin
    s_axi_arready = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    s_axi_rvalid  = 1'b0;
    s_axi_rid     = r_arid;
    s_axi_rdata   = '0;
    s_axi_rresp   = 2'b00;
    s_axi_rlast   = 1'b0;
    s_axi_ruser   = '0;
    if (!rst) begin
      case (r_state)
        ST_IDLE:   s_axi_arready = 1'b1;
        ST_FWD_AR: m_axi_arvalid = 1'b1;
        ST_FWD_R: begin
          s_axi_rvalid = m_axi_rvalid;
          s_axi_rid    = m_axi_rid;
          s_axi_rdata  = m_axi_rdata;
          s_axi_rresp  = m_axi_rresp;
          s_axi_rlast  = m_axi_rlast;
          s_axi_ruser  = m_axi_ruser;
          m_axi_rready = s_axi_rready;
        end
        ST_ERR_R: begin
          s_axi_rvalid = 1'b1;
          s_axi_rresp  = 2'b11;
          s_axi_rlast  = (r_beat_cnt == 8'd0);
        end
        default: ;
      endcase
    end
  end

  assign m_axi_arid         = r_arid;
  assign m_axi_araddr       = r_araddr;
  assign m_axi_arlen        = r_arlen;
  assign m_axi_arsize       = r_arsize;
  assign m_axi_arburst      = r_arburst;
  assign m_axi_arlock       = r_arlock;
  assign m_axi_arcache      = r_arcache;
  assign m_axi_arprot       = r_arprot;
  assign m_axi_arqos        = r_arqos;
  assign m_axi_arregion     = r_arregion;
  assign m_axi_aruser       = r_aruser;
  assign pmp_addr_o         = r_araddr;
  assign denied_cnt_o       = r_denied_cnt;
  assign last_denied_addr_o = r_last_denied_addr;

endmodule
